educell_esmunit_reg: RTL and testbench

- Per-cell ESM history capture stage in the EDU, directly upstream of the per-cell ESM index extractor.
- Takes one raw syndrome measurement bit per ESM round and turns it into a detection-event bit: the current measurement XOR the previous one.
- Packs the detection events of AQMEAS_TH consecutive rounds into esm_reg, then hands the window downstream with a valid/ack handshake.
- Bit r of esm_reg is round r of the window, so the lowest set bits are the earliest events.

---
 rtl/educell_esmunit_reg.sv | 121 ++++++++++++
 tb/tb_educell_esmunit_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/educell_esmunit_reg.sv
// Per-cell ESM history capture: turns raw syndrome bits into detection events
// (current XOR previous) and packs AQMEAS_TH rounds into a window with valid/ack.
`ifndef AQMEAS_TH
`define AQMEAS_TH 4
`endif

module educell_esmunit_reg #(
  parameter int AQMEAS_TH = `AQMEAS_TH,
  parameter int CNT_W     = $clog2(AQMEAS_TH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 meas_valid,
  input  logic                 meas_bit,
  input  logic                 esm_ack,
  output logic [AQMEAS_TH-1:0] esm_reg,
  output logic                 esm_valid,
  output logic [CNT_W-1:0]     round_cnt,
  output logic                 has_event,
  output logic                 multi_event,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [AQMEAS_TH-1:0]   r_esm;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_last_bit;
  logic                   r_overflow;

  state_t                 w_state_next;
  logic [AQMEAS_TH-1:0]   w_esm_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_last_bit_next;
  logic                   w_overflow_next;

  logic                   w_event;
  logic [AQMEAS_TH-1:0]   w_round_mask;

  assign w_event      = meas_bit ^ r_last_bit;
  assign w_round_mask = AQMEAS_TH'(1) << r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_esm      <= '0;
      r_cnt      <= '0;
      r_last_bit <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_esm      <= w_esm_next;
      r_cnt      <= w_cnt_next;
      r_last_bit <= w_last_bit_next;
      r_overflow <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_esm_next      = r_esm;
    w_cnt_next      = r_cnt;
    w_last_bit_next = r_last_bit;
    w_overflow_next = r_overflow;

    case (r_state)
      S_COLLECT: begin
        if (meas_valid) begin
          w_esm_next      = (r_esm & ~w_round_mask) | (w_round_mask & {AQMEAS_TH{w_event}});
          w_cnt_next      = r_cnt + CNT_W'(1);
          w_last_bit_next = meas_bit;
          if (r_cnt == CNT_W'(AQMEAS_TH - 1)) begin
            w_state_next = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (esm_ack) begin
          // Ack retires the window first; a coincident measurement opens the next one.
          w_state_next = S_COLLECT;
          w_esm_next   = '0;
          w_cnt_next   = '0;
          if (meas_valid) begin
            w_esm_next      = AQMEAS_TH'(w_event);
            w_cnt_next      = CNT_W'(1);
            w_last_bit_next = meas_bit;
            if (AQMEAS_TH == 1) begin
              w_state_next = S_FULL;
            end
          end
        end else if (meas_valid) begin
          w_overflow_next = 1'b1;
        end
      end
      default: begin
      end
    endcase

    if (init) begin
      w_state_next    = S_COLLECT;
      w_esm_next      = '0;
      w_cnt_next      = '0;
      w_last_bit_next = 1'b0;
      w_overflow_next = 1'b0;
    end
  end

  assign esm_reg     = r_esm;
  assign round_cnt   = r_cnt;
  assign overflow    = r_overflow;
  assign esm_valid   = (r_state == S_FULL);
  assign has_event   = |r_esm;
  assign multi_event = |(r_esm & (r_esm - AQMEAS_TH'(1)));

endmodule

// File: tb/tb_educell_esmunit_reg.sv
// Directed bench for educell_esmunit_reg with AQMEAS_TH=4.
`timescale 1ns/1ps

module tb_educell_esmunit_reg;

  localparam int TH = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          init;
  logic          meas_valid;
  logic          meas_bit;
  logic          esm_ack;
  logic [TH-1:0] esm_reg;
  logic          esm_valid;
  logic [CW-1:0] round_cnt;
  logic          has_event;
  logic          multi_event;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  educell_esmunit_reg #(.AQMEAS_TH(TH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .meas_valid (meas_valid),
    .meas_bit   (meas_bit),
    .esm_ack    (esm_ack),
    .esm_reg    (esm_reg),
    .esm_valid  (esm_valid),
    .round_cnt  (round_cnt),
    .has_event  (has_event),
    .multi_event(multi_event),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [TH-1:0] bits);
    for (int i = 0; i < TH; i++) begin
      meas_valid = 1'b1;
      meas_bit   = bits[i];
      step();
    end
    meas_valid = 1'b0;
    meas_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; meas_valid = 1'b0; meas_bit = 1'b0; esm_ack = 1'b0;
    step(); step();
    n_checks++; if (esm_reg !== 4'b0000) begin n_errors++; $display("FAIL reset_esm got %b want 0000", esm_reg); end
    n_checks++; if (round_cnt !== 3'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", round_cnt); end
    n_checks++; if (esm_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", esm_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_checks++; if ({has_event, multi_event} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got %b want 00", {has_event, multi_event}); end
    rst = 1'b0;
    meas_valid = 1'b1; meas_bit = 1'b1; step(); meas_valid = 1'b0;
    n_checks++; if (round_cnt !== 3'd0) begin n_errors++; $display("FAIL idle_ignore_cnt got %0d want 0", round_cnt); end
    $display("reset done");
  endtask

  task automatic test_window();
    init = 1'b1; step(); init = 1'b0;
    meas_valid = 1'b1;
    meas_bit = 1'b0; step();
    meas_bit = 1'b1; step();
    meas_bit = 1'b1; step();
    n_checks++; if (esm_valid !== 1'b0 || round_cnt !== 3'd3) begin n_errors++; $display("FAIL win_partial got valid=%b cnt=%0d want 0/3", esm_valid, round_cnt); end
    meas_bit = 1'b0; step();
    meas_valid = 1'b0;
    n_checks++; if (esm_reg !== 4'b1010) begin n_errors++; $display("FAIL win_esm got %b want 1010", esm_reg); end
    n_checks++; if (round_cnt !== 3'd4 || esm_valid !== 1'b1) begin n_errors++; $display("FAIL win_full got cnt=%0d valid=%b want 4/1", round_cnt, esm_valid); end
    n_checks++; if ({has_event, multi_event} !== 2'b11) begin n_errors++; $display("FAIL win_flags got %b want 11", {has_event, multi_event}); end
    step();
    n_checks++; if (esm_reg !== 4'b1010 || esm_valid !== 1'b1) begin n_errors++; $display("FAIL win_hold got %b/%b want 1010/1", esm_reg, esm_valid); end
    $display("window esm_reg=%b round_cnt=%0d", esm_reg, round_cnt);
  endtask

  task automatic test_ack_continuity();
    esm_ack = 1'b1; step(); esm_ack = 1'b0;
    n_checks++; if (esm_valid !== 1'b0 || esm_reg !== 4'b0000 || round_cnt !== 3'd0) begin n_errors++; $display("FAIL ack_clear got v=%b esm=%b cnt=%0d want 0/0000/0", esm_valid, esm_reg, round_cnt); end
    feed(4'b0000);
    n_checks++; if (esm_reg !== 4'b0000 || esm_valid !== 1'b1) begin n_errors++; $display("FAIL zero_win got %b/%b want 0000/1", esm_reg, esm_valid); end
    n_checks++; if ({has_event, multi_event} !== 2'b00) begin n_errors++; $display("FAIL zero_flags got %b want 00", {has_event, multi_event}); end
    esm_ack = 1'b1; step(); esm_ack = 1'b0;
    feed(4'b1111);
    n_checks++; if (esm_reg !== 4'b0001 || esm_valid !== 1'b1) begin n_errors++; $display("FAIL one_win got %b/%b want 0001/1", esm_reg, esm_valid); end
    n_checks++; if ({has_event, multi_event} !== 2'b10) begin n_errors++; $display("FAIL one_flags got %b want 10", {has_event, multi_event}); end
    $display("continuity esm_reg=%b", esm_reg);
  endtask

  task automatic test_overflow();
    esm_ack = 1'b1; step(); esm_ack = 1'b0;
    feed(4'b1111);
    n_checks++; if (esm_reg !== 4'b0000 || esm_valid !== 1'b1) begin n_errors++; $display("FAIL carry_last got %b/%b want 0000/1", esm_reg, esm_valid); end
    meas_valid = 1'b1; meas_bit = 1'b0; step(); meas_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1 || esm_reg !== 4'b0000 || round_cnt !== 3'd4 || esm_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_drop got ovf=%b esm=%b cnt=%0d v=%b want 1/0000/4/1", overflow, esm_reg, round_cnt, esm_valid); end
    esm_ack = 1'b1; step(); esm_ack = 1'b0;
    n_checks++; if (overflow !== 1'b1 || esm_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_sticky got ovf=%b v=%b want 1/0", overflow, esm_valid); end
    init = 1'b1; step(); init = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_init got %b want 0", overflow); end
    $display("overflow cleared by init");
  endtask

  task automatic test_ack_and_meas();
    feed(4'b0000);
    esm_ack = 1'b1; meas_valid = 1'b1; meas_bit = 1'b1; step();
    esm_ack = 1'b0; meas_valid = 1'b0; meas_bit = 1'b0;
    n_checks++; if (esm_reg !== 4'b0001 || round_cnt !== 3'd1 || esm_valid !== 1'b0) begin n_errors++; $display("FAIL ack_meas got esm=%b cnt=%0d v=%b want 0001/1/0", esm_reg, round_cnt, esm_valid); end
    meas_valid = 1'b1; meas_bit = 1'b1; step(); meas_valid = 1'b0;
    n_checks++; if (esm_reg !== 4'b0001 || round_cnt !== 3'd2) begin n_errors++; $display("FAIL ack_meas_next got esm=%b cnt=%0d want 0001/2", esm_reg, round_cnt); end
    $display("ack+meas esm_reg=%b round_cnt=%0d", esm_reg, round_cnt);
  endtask

  task automatic test_init_priority();
    init = 1'b1; meas_valid = 1'b1; meas_bit = 1'b1; step();
    init = 1'b0; meas_valid = 1'b0;
    n_checks++; if (esm_reg !== 4'b0000 || round_cnt !== 3'd0) begin n_errors++; $display("FAIL init_prio got esm=%b cnt=%0d want 0000/0", esm_reg, round_cnt); end
    meas_valid = 1'b1; meas_bit = 1'b1; step(); meas_valid = 1'b0;
    n_checks++; if (esm_reg !== 4'b0001 || round_cnt !== 3'd1) begin n_errors++; $display("FAIL init_last got esm=%b cnt=%0d want 0001/1", esm_reg, round_cnt); end
    $display("init priority esm_reg=%b", esm_reg);
  endtask

  task automatic test_async_reset();
    init = 1'b1; step(); init = 1'b0;
    meas_valid = 1'b1;
    meas_bit = 1'b1; step();
    meas_bit = 1'b0; step();
    meas_valid = 1'b0;
    n_checks++; if (esm_reg !== 4'b0011 || multi_event !== 1'b1) begin n_errors++; $display("FAIL pre_rst got esm=%b multi=%b want 0011/1", esm_reg, multi_event); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (esm_reg !== 4'b0000 || round_cnt !== 3'd0 || esm_valid !== 1'b0 || has_event !== 1'b0) begin n_errors++; $display("FAIL async_rst got esm=%b cnt=%0d v=%b he=%b want 0000/0/0/0", esm_reg, round_cnt, esm_valid, has_event); end
    step(); rst = 1'b0;
    meas_valid = 1'b1; meas_bit = 1'b1; step(); step(); meas_valid = 1'b0;
    n_checks++; if (esm_reg !== 4'b0000 || round_cnt !== 3'd0) begin n_errors++; $display("FAIL post_rst_idle got esm=%b cnt=%0d want 0000/0", esm_reg, round_cnt); end
    $display("async reset done");
  endtask

  initial begin
    test_reset();
    test_window();
    test_ack_continuity();
    test_overflow();
    test_ack_and_meas();
    test_init_priority();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
